// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and framing constants.
package uart_pkg;

    localparam int UART_DBITS   = 8;
    localparam int UART_MIN_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Register-block side of the UART receiver: read/clear strobes, holding register and status flags.
interface uart_rx_if;

    logic       rx_rd;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_busy;
    logic       frm_err;
    logic       ovr_err;
    logic       par_err;

    modport master (
        output rx_rd, err_clr,
        input  rx_data, rx_rdy, rx_busy, frm_err, ovr_err, par_err
    );

    modport slave (
        input  rx_rd, err_clr,
        output rx_data, rx_rdy, rx_busy, frm_err, ovr_err, par_err
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter with divider clamp; tick is a single-cycle pulse at count 0.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic            half,
    input  logic [XLEN-1:0] div,
    output logic            tick
);

    function automatic logic [XLEN-1:0] clamp_div(input logic [XLEN-1:0] d);
        return (d < XLEN'(UART_MIN_DIV)) ? XLEN'(UART_MIN_DIV) : d;
    endfunction

    logic [XLEN-1:0] cnt;
    logic [XLEN-1:0] period;
    logic [XLEN-1:0] load_val;
    logic            armed;

    assign period   = clamp_div(div);
    assign load_val = half ? (period >> 1) : period;
    assign tick     = armed && (cnt == '0);

    // Loading V stores V-1 so the tick lands on the V-th following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val - XLEN'(1);
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) armed <= 1'b0;
            else           cnt   <= cnt - XLEN'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, deframing FSM, shift register and one-deep holding register.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            uart_en,
    input  logic [XLEN-1:0] refclk_st,
    input  logic            rxd,
`ifdef UART_RX_PARITY_EN
    input  logic            par_odd,
`endif
    uart_rx_if.slave        bus
);

    logic                  rxd_p0, rxd_s;
    uart_state_e           state, state_nxt;
    logic                  tick, cnt_load, cnt_half, shift_en, bit_clr, done;
    logic [2:0]            bit_idx;
    logic [UART_DBITS-1:0] shift;
    logic [7:0]            data_q;
    logic                  rdy_q, frm_q, ovr_q;
    logic                  accept, overrun;

    // Input synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_p0 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_s  <= rxd_p0;
        end
    end

    uart_baud_cnt #(.XLEN(XLEN)) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~uart_en),
        .load  (cnt_load),
        .half  (cnt_half),
        .div   (refclk_st),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        state <= IDLE;
        else if (!uart_en) state <= IDLE;
        else               state <= state_nxt;
    end

`ifdef UART_RX_PARITY_EN
    logic par_chk, par_bad, par_q;
`endif

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_half  = 1'b0;
        shift_en  = 1'b0;
        bit_clr   = 1'b0;
        done      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    cnt_load  = 1'b1;
                    cnt_half  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_load  = 1'b1;
                        bit_clr   = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    if (bit_idx == 3'(UART_DBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_chk   = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Completing mid-stop-bit leaves half a bit to resynchronise on the next start edge.
                if (tick) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            shift   <= '0;
        end else if (bit_clr) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= {rxd_s, shift[UART_DBITS-1:1]};
        end
    end

    // Holding register and sticky flags
    assign accept  = uart_en && done && (!rdy_q || bus.rx_rd);
    assign overrun = uart_en && done && rdy_q && !bus.rx_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      data_q <= '0;
        else if (accept) data_q <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            frm_q <= 1'b0;
            ovr_q <= 1'b0;
        end else if (!uart_en) begin
            rdy_q <= 1'b0;
            frm_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (accept)           rdy_q <= 1'b1;
            else if (bus.rx_rd)   rdy_q <= 1'b0;
            if (accept && !rxd_s) frm_q <= 1'b1;
            else if (bus.err_clr) frm_q <= 1'b0;
            if (overrun)          ovr_q <= 1'b1;
            else if (bus.err_clr) ovr_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       par_bad <= 1'b0;
        else if (par_chk) par_bad <= rxd_s ^ (^shift) ^ par_odd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  par_q <= 1'b0;
        else if (!uart_en)           par_q <= 1'b0;
        else if (accept && par_bad)  par_q <= 1'b1;
        else if (bus.err_clr)        par_q <= 1'b0;
    end

    assign bus.par_err = par_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.rx_data = data_q;
    assign bus.rx_rdy  = rdy_q;
    assign bus.rx_busy = (state != IDLE);
    assign bus.frm_err = frm_q;
    assign bus.ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level expectation model checked every cycle, plus hand-computed pins.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_en = 1'b0;
    logic        rxd = 1'b1;
    logic [31:0] refclk_st = 32'd16;
    logic        par_odd_v = 1'b0;

    uart_rx_if bus ();

    uart_rx #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_en   (uart_en),
        .refclk_st (refclk_st),
        .rxd       (rxd),
`ifdef UART_RX_PARITY_EN
        .par_odd   (par_odd_v),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         d;
        int         cmp;
        logic [7:0] b;
        logic       stop_ok;
        logic       par_bad;
        logic       glitch;
    } frame_t;

    frame_t     q[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         chk_on = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_rdy = 1'b0, m_busy = 1'b0, m_frm = 1'b0, m_ovr = 1'b0, m_par = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Frame-level model: each frame is a scheduled completion at its stop sample cycle.
    always @(posedge clk) begin
        frame_t r;
        logic   comp, nf, no, np;
        if (!rst_n) begin
            q.delete();
            m_data = 8'h00; m_rdy = 0; m_busy = 0; m_frm = 0; m_ovr = 0; m_par = 0;
        end else if (!uart_en) begin
            q.delete();
            m_rdy = 0; m_busy = 0; m_frm = 0; m_ovr = 0; m_par = 0;
        end else begin
            comp = 0; nf = 0; no = 0; np = 0;
            if (q.size() > 0 && q[0].cmp == cyc) begin
                r = q.pop_front();
                comp = !r.glitch;
            end
            if (comp) begin
                if (!m_rdy || bus.rx_rd) begin
                    m_data = r.b; m_rdy = 1; nf = !r.stop_ok; np = r.par_bad;
                end else begin
                    no = 1;
                end
            end else if (bus.rx_rd) begin
                m_rdy = 0;
            end
            m_frm  = nf | (m_frm & !bus.err_clr);
            m_ovr  = no | (m_ovr & !bus.err_clr);
            m_par  = np | (m_par & !bus.err_clr);
            m_busy = (q.size() > 0) && (cyc >= q[0].d) && (cyc < q[0].cmp);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("rx_rdy",  {31'd0, bus.rx_rdy},  {31'd0, m_rdy});
            check("rx_data", {24'd0, bus.rx_data}, {24'd0, m_data});
            check("rx_busy", {31'd0, bus.rx_busy}, {31'd0, m_busy});
            check("frm_err", {31'd0, bus.frm_err}, {31'd0, m_frm});
            check("ovr_err", {31'd0, bus.ovr_err}, {31'd0, m_ovr});
            check("par_err", {31'd0, bus.par_err}, {31'd0, m_par});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic pulse_rd();
        bus.rx_rd = 1'b1; step(1); bus.rx_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1; step(1); bus.err_clr = 1'b0;
    endtask

    // Drives one frame on the pin; bit i of the frame occupies pin cycles [k+i*n, k+(i+1)*n).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic use_par, input logic pbit);
        int     n, h, k;
        frame_t r, g;
        n = (refclk_st < 32'd4) ? 4 : int'(refclk_st);
        h = n / 2;
        k = cyc;
        r.d       = k + 2;
        r.cmp     = r.d + h + 9 * n + (use_par ? n : 0);
        r.b       = b;
        r.stop_ok = stop;
        r.par_bad = use_par && (pbit != ((^b) ^ par_odd_v));
        r.glitch  = 1'b0;
        q.push_back(r);
        if (!stop) begin
            // A low stop bit is still low right after completion, so a false start follows and is rejected.
            g.d = r.cmp + 1; g.cmp = g.d + h; g.b = 8'h00;
            g.stop_ok = 1'b1; g.par_bad = 1'b0; g.glitch = 1'b1;
            q.push_back(g);
        end
        rxd = 1'b0; step(n);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i]; step(n);
        end
        if (use_par) begin
            rxd = pbit; step(n);
        end
        rxd = stop; step(n);
        rxd = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        frame_t g;
        bus.rx_rd = 1'b0;
        bus.err_clr = 1'b0;
        step(3);
        rst_n = 1'b1;
        uart_en = 1'b1;
        chk_on = 1'b1;
        step(2);
        check("reset_rdy",  {31'd0, bus.rx_rdy},  32'd0);
        check("reset_data", {24'd0, bus.rx_data}, 32'h00);
        check("reset_busy", {31'd0, bus.rx_busy}, 32'd0);

        // Single byte at N=16: completion visible at D+153
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
            begin
                k = cyc;
                wait_cyc(k + 2);   check("busy_at_D",   {31'd0, bus.rx_busy}, 32'd0);
                wait_cyc(k + 3);   check("busy_at_D1",  {31'd0, bus.rx_busy}, 32'd1);
                wait_cyc(k + 154); check("rdy_at_D152", {31'd0, bus.rx_rdy},  32'd0);
                wait_cyc(k + 155); check("rdy_at_D153", {31'd0, bus.rx_rdy},  32'd1);
                check("data_a5",  {24'd0, bus.rx_data}, 32'hA5);
                check("busy_end", {31'd0, bus.rx_busy}, 32'd0);
                check("frm_a5",   {31'd0, bus.frm_err}, 32'd0);
            end
        join
        step(5);
        pulse_rd();
        check("rdy_after_rd", {31'd0, bus.rx_rdy}, 32'd0);
        step(5);

        // Framing error then clear
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        step(30);
        check("data_3c", {24'd0, bus.rx_data}, 32'h3C);
        check("rdy_3c",  {31'd0, bus.rx_rdy},  32'd1);
        check("frm_3c",  {31'd0, bus.frm_err}, 32'd1);
        pulse_clr();
        check("frm_cleared", {31'd0, bus.frm_err}, 32'd0);
        pulse_rd();
        step(5);

        // Overrun with back-to-back frames
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        step(20);
        check("data_ovr", {24'd0, bus.rx_data}, 32'h11);
        check("ovr_set",  {31'd0, bus.ovr_err}, 32'd1);
        pulse_clr();
        check("ovr_cleared", {31'd0, bus.ovr_err}, 32'd0);
        fork
            send_frame(8'h33, 1'b1, 1'b0, 1'b0);
            begin
                k = cyc;
                wait_cyc(k + 154);
                pulse_rd();
            end
        join
        step(20);
        check("data_33", {24'd0, bus.rx_data}, 32'h33);
        check("rdy_33",  {31'd0, bus.rx_rdy},  32'd1);
        check("ovr_33",  {31'd0, bus.ovr_err}, 32'd0);
        pulse_rd();
        step(5);

        // Start-bit glitch: 4 clk low
        k = cyc;
        g.d = k + 2; g.cmp = k + 10; g.b = 8'h00; g.stop_ok = 1'b1; g.par_bad = 1'b0; g.glitch = 1'b1;
        q.push_back(g);
        rxd = 1'b0; step(4); rxd = 1'b1;
        wait_cyc(k + 5);  check("glitch_busy", {31'd0, bus.rx_busy}, 32'd1);
        wait_cyc(k + 12); check("glitch_idle", {31'd0, bus.rx_busy}, 32'd0);
        check("glitch_rdy", {31'd0, bus.rx_rdy}, 32'd0);
        step(10);

        // Disable mid-frame with a full holding register
        send_frame(8'h66, 1'b1, 1'b0, 1'b0);
        step(10);
        fork
            send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
            begin
                k = cyc;
                wait_cyc(k + 4 * 16 + 8);
                uart_en = 1'b0;
                step(1);
                check("dis_busy", {31'd0, bus.rx_busy}, 32'd0);
                check("dis_rdy",  {31'd0, bus.rx_rdy},  32'd0);
                check("dis_data", {24'd0, bus.rx_data}, 32'h66);
            end
        join
        step(20);
        uart_en = 1'b1;
        step(5);

        // Divider clamp: refclk_st=1 behaves as N=4, completion at D+H+9N+1 = D+39
        refclk_st = 32'd1;
        fork
            send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
            begin
                k = cyc;
                wait_cyc(k + 40); check("clamp_rdy_early", {31'd0, bus.rx_rdy}, 32'd0);
                wait_cyc(k + 41); check("clamp_rdy",       {31'd0, bus.rx_rdy}, 32'd1);
                check("clamp_data", {24'd0, bus.rx_data}, 32'h5A);
            end
        join
        step(10);
        pulse_rd();
        step(5);

`ifdef UART_RX_PARITY_EN
        // Even parity, 0x07 needs parity bit 1; sending 0 is an error
        refclk_st = 32'd16;
        par_odd_v = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        step(20);
        check("par_data", {24'd0, bus.rx_data}, 32'h07);
        check("par_err",  {31'd0, bus.par_err}, 32'd1);
        pulse_clr();
        pulse_rd();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        step(20);
        check("par_ok", {31'd0, bus.par_err}, 32'd0);
        pulse_rd();
        step(5);
`endif

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the peripheral bus UART, the receive-side counterpart to the existing transmit path. It samples the `rxd` pin using the same 32-bit bit-period value `refclk_st` that the transmitter uses, and deframes 8N1 characters (8 data bits, no parity, 1 stop bit; optional parity, see Configuration). It holds each received byte in a one-deep holding register, with ready, framing-error and overrun flags for the UART register block.

## Interface
- `XLEN`, 32, bus and `refclk_st` width.
- `clk`  in  1  global clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `uart_en`  in  1  UART enable; low forces IDLE and clears all flags.
- `refclk_st`  in  XLEN  bit period in clk cycles; values below 4 are treated as 4.
- `rxd`  in  1  serial input from the pin; asynchronous; idles high.
- `rx_rd`  in  1  one-cycle pulse on a register read of the RX data register; clears `rx_rdy`.
- `err_clr`  in  1  one-cycle pulse; clears `frm_err`, `ovr_err` and `par_err`.
- `rx_data`  out  8  last accepted byte; reset value 0x00.
- `rx_rdy`  out  1  holding register full; reset value 0.
- `rx_busy`  out  1  high in any state other than IDLE; reset value 0.
- `frm_err`  out  1  sticky: stop bit sampled as 0; reset value 0.
- `ovr_err`  out  1  sticky: a byte completed while `rx_rdy` was 1; reset value 0.
- `par_err`  out  1  sticky parity error; tied to 0 when parity is compiled out; reset value 0.

## Operation
- `rxd` passes through a 2-flop synchronizer, reset value 1, to give `rxd_s`. All decisions use `rxd_s`.
- `N` = max(`refclk_st`, 4). `H` = N>>1.
- The bit counter is a down-counter of width XLEN. Loading V means the sample is taken on the V-th following cycle.
- **IDLE:** when `rxd_s` is 0, load H and go to START.
- **START:** at the sample point:
  - If `rxd_s` is 1, treat it as a glitch. Return to IDLE with no flag.
  - Otherwise load N, clear the bit index and go to DATA.
- **DATA:** at each sample point, shift `rxd_s` in LSB first and load N.
  - After bit index 7, go to PARITY if parity is compiled in, otherwise STOP.
- **PARITY:** at the sample point, compare `rxd_s` with the expected parity bit, load N and go to STOP.
- **STOP:** at the sample point, complete the character and go to IDLE immediately. This takes effect half a bit early, for resynchronisation.
- **Completion:**
  - If `rx_rdy` is 0: load the shift register into `rx_data` and set `rx_rdy`. If the stop bit is 0, set `frm_err`. If parity mismatched, set `par_err`.
  - If `rx_rdy` is 1: discard the byte, keep `rx_data` and set `ovr_err`. `frm_err` and `par_err` are not updated.
- **Completion and `rx_rd` in the same cycle:** the read is honoured and the new byte is loaded. `rx_rdy` stays 1 and there is no overrun.
- **`rx_rd` when `rx_rdy` is 0:** no effect.
- **`err_clr` in the same cycle as a new error:** the error wins and the flag stays set.
- **`uart_en` low:** takes effect synchronously on the next edge.
  - State goes to IDLE and the counter is cleared.
  - `rx_rdy`, `frm_err`, `ovr_err` and `par_err` are cleared.
  - `rx_data` is held.
- **Async reset mid-frame:** every flop returns to its reset value. The next falling edge on `rxd_s` starts a new frame.
- **`refclk_st` changed mid-frame:** the new value applies from the next counter load.

## Timing
- Synchronizer latency: 2 clk from the `rxd` pin to `rxd_s`.
- D is the first cycle in which IDLE sees `rxd_s` = 0.
- Sample points:
  - Start bit: D+H.
  - Data bit i: D+H+(i+1)·N.
  - Parity bit, if enabled: D+H+9·N.
  - Stop bit: D+H+9·N, or D+H+10·N with parity.
- `rx_rdy`, `rx_data` and the error flags update on the cycle after the stop sample.
- `rx_busy` rises at D+1 and falls together with the `rx_rdy` update.
- `rx_rdy` falls on the cycle after `rx_rd`.
- Back-to-back frames with zero idle time between them are received.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists.
  - The input `par_odd` (1 bit) selects the parity mode: 0 = even, 1 = odd.
  - `par_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state and no `par_odd` port.
  - `par_err` is constant 0.
  - The frame is 8N1.

## Structure
- Package `uart_pkg`:
  - State encoding: IDLE, START, DATA, PARITY, STOP.
  - `UART_DBITS` = 8.
  - `UART_MIN_DIV` = 4.
- Sub-module `uart_baud_cnt`: the loadable down-counter with clamp. Outputs a one-cycle `tick` at count 0, and shares the clamp logic with the TX path.
- The synchronizer, FSM, shift register and holding register live in `uart_rx`.

## Test plan
- **Single byte:** `refclk_st`=16, send 0xA5 (8N1). Expect `rx_data`=0xA5, `rx_rdy` rising at D+153, `frm_err`=0.
- **Framing error:** `refclk_st`=16, send 0x3C with the stop bit forced to 0. Expect `rx_data`=0x3C, `rx_rdy`=1, `frm_err`=1; `err_clr` then returns it to 0.
- **Overrun:** send 0x11 then 0x22 with no `rx_rd` between them. Expect `rx_data`=0x11 and `ovr_err`=1. Then send `rx_rd` coincident with completion of 0x33: expect `rx_data`=0x33, `rx_rdy`=1, no new overrun.
- **Start glitch:** `refclk_st`=16, drive `rxd` low for 4 clk. Expect return to IDLE, `rx_busy` pulse only, `rx_rdy`=0.
- **Disable mid-frame and clamp:** drop `uart_en` during bit 3 of a frame. Expect IDLE and all flags 0 next cycle. Then set `refclk_st`=1 and send 0x5A. Expect correct reception at the N=4 timing.
- **Parity (with `UART_RX_PARITY_EN`):** even parity, send 0x07 with parity bit 0. Expect `par_err`=1 and `rx_data`=0x07.
